barrel_shifter_pipe: RTL and testbench

//  Parametrised, multi-mode barrel shifter with valid/ready handshake on both sides.

---
 rtl/shifter_pkg.sv | 34 +++
 rtl/shift_stage.sv | 95 +++++++++
 rtl/barrel_shifter_pipe.sv | 123 ++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the streaming barrel shifter.
//   MODE_*     : operation encodings carried alongside each beat
//   MODE_W     : width of the mode field
//   bitrev()   : reverses the low `width` bits of a MAX_WIDTH-wide vector
//   is_right() : true for modes that run through the reversed (right-shift) path
package shifter_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SLL = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SRL = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SRA = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'b100;

  // Upper bound on WIDTH; callers zero-extend into and truncate out of this width.
  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_WIDTH);

  function automatic logic [MAX_WIDTH-1:0] bitrev(input logic [MAX_WIDTH-1:0] d,
                                                  input int unsigned          width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) r[MAX_IDX_W'(i)] = d[MAX_IDX_W'(width - 1 - i)];
    end
    return r;
  endfunction

  function automatic logic is_right(input logic [MODE_W-1:0] mode);
    return (mode == MODE_SRL) || (mode == MODE_SRA) || (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One level of the barrel shifter: conditional left shift by 2^K with per-mode fill,
// followed by an optional valid/ready pipeline register.
//   clk, rst_n          : clock, synchronous active-low reset
//   i_valid / o_ready   : upstream handshake (o_ready = this stage's load condition)
//   i_data, i_shamt,
//   i_mode, i_sign      : beat payload from the previous level
//   o_valid / i_ready   : downstream handshake
//   o_data, o_shamt,
//   o_mode, o_sign      : beat payload towards the next level
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned K       = 0,
  parameter bit          REG     = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [MODE_W-1:0]  i_mode,
  input  logic               i_sign,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_data,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic [MODE_W-1:0]  o_mode,
  output logic               o_sign
);

  localparam int unsigned S = 1 << K;

  logic [S-1:0]     w_fill;
  logic [WIDTH-1:0] w_shifted;

  // Right-direction modes arrive bit-reversed, so every mode is a left shift here.
  always_comb begin
    case (i_mode)
      MODE_SRA:           w_fill = {S{i_sign}};
      MODE_ROL, MODE_ROR: w_fill = i_data[WIDTH-1 -: S];
      default:            w_fill = '0;
    endcase
  end

  // Reserved modes (above ROR) pass the data through untouched.
  always_comb begin
    w_shifted = i_data;
    if (i_shamt[K] && (i_mode <= MODE_ROR)) begin
      w_shifted = {i_data[WIDTH-S-1:0], w_fill};
    end
  end

  if (REG) begin : g_reg
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_shamt;
    logic [MODE_W-1:0]  r_mode;
    logic               r_sign;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_shamt <= '0;
        r_mode  <= '0;
        r_sign  <= 1'b0;
      end else if (o_ready) begin
        r_valid <= i_valid;
        r_data  <= w_shifted;
        r_shamt <= i_shamt;
        r_mode  <= i_mode;
        r_sign  <= i_sign;
      end
    end

    // Load when empty or when the next level takes our beat this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shamt = r_shamt;
    assign o_mode  = r_mode;
    assign o_sign  = r_sign;
  end else begin : g_comb
    assign o_ready = i_ready;
    assign o_valid = i_valid;
    assign o_data  = w_shifted;
    assign o_shamt = i_shamt;
    assign o_mode  = i_mode;
    assign o_sign  = i_sign;
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Streaming multi-mode barrel shifter (SLL, SRL, SRA, ROL, ROR, pass) with valid/ready
// on both sides. SHAMT_W shift levels, then a result register that also holds out_zero.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : input handshake
//   in_data, in_shamt,
//   in_mode               : operand, shift amount, operation
//   out_valid / out_ready : output handshake
//   out_data, out_zero    : result and result==0 flag
// PIPELINE=1 registers every level except the last, which feeds the result register
// directly, giving SHAMT_W cycles of latency. PIPELINE=0 leaves only the result register.
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SHAMT_W  = $clog2(WIDTH),
  parameter bit          PIPELINE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [MODE_W-1:0]  in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_zero;
  logic             w_out_load;
  logic [WIDTH-1:0] w_final;

  assign w_out_load = !r_out_valid || out_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic               w_in_valid;
    logic [WIDTH-1:0]   w_in_data;
    logic [SHAMT_W-1:0] w_in_shamt;
    logic [MODE_W-1:0]  w_in_mode;
    logic               w_in_sign;
    logic               w_ready;
    logic               w_next_ready;
    logic               w_valid;
    logic [WIDTH-1:0]   w_data;
    logic [SHAMT_W-1:0] w_shamt;
    logic [MODE_W-1:0]  w_mode;
    logic               w_sign;

    if (k == 0) begin : g_entry
      // Right-direction modes are bit-reversed here and undone at the exit.
      assign w_in_valid = in_valid;
      assign w_in_data  = is_right(in_mode) ? WIDTH'(bitrev(MAX_WIDTH'(in_data), WIDTH))
                                            : in_data;
      assign w_in_shamt = in_shamt;
      assign w_in_mode  = in_mode;
      assign w_in_sign  = in_data[WIDTH-1];
    end else begin : g_chain
      assign w_in_valid = g_stage[k-1].w_valid;
      assign w_in_data  = g_stage[k-1].w_data;
      assign w_in_shamt = g_stage[k-1].w_shamt;
      assign w_in_mode  = g_stage[k-1].w_mode;
      assign w_in_sign  = g_stage[k-1].w_sign;
    end

    if (k + 1 == SHAMT_W) begin : g_last
      assign w_next_ready = w_out_load;
    end else begin : g_mid
      assign w_next_ready = g_stage[k+1].w_ready;
    end

    shift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .K       (k),
      .REG     (PIPELINE && (k + 1 < SHAMT_W))
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_in_valid),
      .o_ready (w_ready),
      .i_data  (w_in_data),
      .i_shamt (w_in_shamt),
      .i_mode  (w_in_mode),
      .i_sign  (w_in_sign),
      .o_valid (w_valid),
      .i_ready (w_next_ready),
      .o_data  (w_data),
      .o_shamt (w_shamt),
      .o_mode  (w_mode),
      .o_sign  (w_sign)
    );
  end

  assign w_final = is_right(g_stage[SHAMT_W-1].w_mode)
                 ? WIDTH'(bitrev(MAX_WIDTH'(g_stage[SHAMT_W-1].w_data), WIDTH))
                 : g_stage[SHAMT_W-1].w_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid <= g_stage[SHAMT_W-1].w_valid;
      // Keep the last result on the bus when a bubble arrives.
      if (g_stage[SHAMT_W-1].w_valid) begin
        r_out_data <= w_final;
        r_out_zero <= (w_final == '0);
      end
    end
  end

  // Gated so nothing is accepted while reset is held.
  assign in_ready  = rst_n & g_stage[0].w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;
  import shifter_pkg::*;

  typedef struct {
    logic [7:0] data;
    bit         lat;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       drv_valid;
  logic [7:0] drv_data;
  logic [2:0] drv_shamt;
  logic [2:0] drv_mode;
  logic       drv_out_ready;
  int         sel;          // 0: pipelined DUT, 1: single-register DUT
  bit         rand_rdy;

  logic       vld [2];
  logic       ird [2];
  logic       zer [2];
  logic [7:0] dat [2];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  barrel_shifter_pipe #(.WIDTH(8), .PIPELINE(1'b1)) u_dut_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (drv_valid && (sel == 0)),
    .in_ready  (ird[0]),
    .in_data   (drv_data),
    .in_shamt  (drv_shamt),
    .in_mode   (drv_mode),
    .out_valid (vld[0]),
    .out_ready (drv_out_ready),
    .out_data  (dat[0]),
    .out_zero  (zer[0])
  );

  barrel_shifter_pipe #(.WIDTH(8), .PIPELINE(1'b0)) u_dut_flat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (drv_valid && (sel == 1)),
    .in_ready  (ird[1]),
    .in_data   (drv_data),
    .in_shamt  (drv_shamt),
    .in_mode   (drv_mode),
    .out_valid (vld[1]),
    .out_ready (drv_out_ready),
    .out_data  (dat[1]),
    .out_zero  (zer[1])
  );

  // Reference: plain shift/rotate arithmetic on the operand.
  function automatic logic [7:0] ref_model(input logic [7:0] d, input int s,
                                           input logic [2:0] m);
    logic [15:0] w;
    case (m)
      3'd0: return d << s;
      3'd1: return d >> s;
      3'd2: return 8'($signed(d) >>> s);
      3'd3: begin w = {d, d} << s; return w[15:8]; end
      3'd4: begin w = {d, d} >> s; return w[7:0]; end
      default: return d;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void q_push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endfunction
  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t q_front(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void q_pop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  // Monitor: pops the scoreboard when a result transfers, checks stall stability.
  bit         stalled   [2];
  bit         presented [2];
  logic [7:0] held_d    [2];
  logic       held_z    [2];
  exp_t       mon_e;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        stalled[d]   = 1'b0;
        presented[d] = 1'b0;
      end else if (!vld[d]) begin
        if (stalled[d]) chk($sformatf("hold_valid[dut%0d]", d), vld[d], 1);
        stalled[d] = 1'b0;
      end else if (q_size(d) == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output[dut%0d]: got data %02h, required no output", d,
                 dat[d]);
      end else begin
        mon_e = q_front(d);
        if (stalled[d]) begin
          chk($sformatf("hold_data[dut%0d]", d), dat[d], held_d[d]);
          chk($sformatf("hold_zero[dut%0d]", d), zer[d], held_z[d]);
        end
        if (!presented[d]) begin
          presented[d] = 1'b1;
          if (mon_e.lat) chk($sformatf("latency[dut%0d]", d), cyc - mon_e.cyc, lat_of(d));
        end
        if (drv_out_ready) begin
          chk($sformatf("out_data[dut%0d]", d), dat[d], mon_e.data);
          chk($sformatf("out_zero[dut%0d]", d), zer[d], mon_e.data == 8'h00);
          q_pop(d);
          presented[d] = 1'b0;
          stalled[d]   = 1'b0;
        end else begin
          stalled[d] = 1'b1;
          held_d[d]  = dat[d];
          held_z[d]  = zer[d];
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) drv_out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1. Holds drv_valid high after success.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [2:0] m,
                      input logic [7:0] e, input bit lat, input int tmo, output bit ok);
    exp_t x;
    drv_valid = 1'b1;
    drv_data  = d;
    drv_shamt = s;
    drv_mode  = m;
    ok = 1'b0;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (ird[sel]) begin
        ok    = 1'b1;
        x.data = e;
        x.lat  = lat;
        x.cyc  = cyc;
        q_push(sel, x);
        break;
      end
    end
    if (!ok) drv_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_send(input int tmo);
    logic [7:0] d;
    logic [2:0] s;
    logic [2:0] m;
    bit         ok;
    d = 8'($urandom);
    s = 3'($urandom_range(0, 7));
    m = 3'($urandom_range(0, 7));
    send(d, s, m, ref_model(d, int'(s), m), 1'b0, tmo, ok);
    chk("send_accepted", ok, 1);
  endtask

  task automatic idle();
    drv_valid = 1'b0;
  endtask

  task automatic drain(input int d, input int budget);
    int n = 0;
    idle();
    while ((q_size(d) != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk($sformatf("drain_empty[dut%0d]", d), q_size(d), 0);
  endtask

  task automatic sll_sweep();
    logic [7:0] sll_exp [8];
    bit         ok;
    int         t0;
    sll_exp = '{8'h18, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00};
    t0 = cyc;
    for (int s = 0; s < 8; s++) begin
      send(8'b0001_1000, 3'(s), MODE_SLL, sll_exp[s], 1'b1, 10, ok);
      chk("sll_accepted", ok, 1);
    end
    chk("sll_throughput", cyc - t0, 8);
    drain(sel, 40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    int         acc;
    logic [7:0] bp_d [6];
    logic [2:0] bp_s [6];
    logic [2:0] bp_m [6];

    rst_n         = 1'b0;
    drv_valid     = 1'b0;
    drv_data      = '0;
    drv_shamt     = '0;
    drv_mode      = '0;
    drv_out_ready = 1'b0;
    sel           = 0;
    rand_rdy      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_pipe", ird[0], 0);
    chk("rst_in_ready_flat", ird[1], 0);
    chk("rst_out_valid_pipe", vld[0], 0);
    chk("rst_out_data_pipe", dat[0], 0);
    chk("rst_out_zero_pipe", zer[0], 0);
    chk("rst_out_valid_flat", vld[1], 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    drv_out_ready = 1'b1;

    // Directed SLL sweep, back-to-back, pipelined DUT.
    sll_sweep();

    // Directed mode cases.
    send(8'h90, 3'd1, MODE_SRA, 8'hC8, 1'b1, 10, ok);
    send(8'h90, 3'd7, MODE_SRA, 8'hFF, 1'b1, 10, ok);
    send(8'h90, 3'd7, MODE_SRL, 8'h01, 1'b1, 10, ok);
    send(8'h81, 3'd1, MODE_ROL, 8'h03, 1'b1, 10, ok);
    send(8'h81, 3'd1, MODE_ROR, 8'hC0, 1'b1, 10, ok);
    send(8'h5A, 3'd4, 3'b111, 8'h5A, 1'b1, 10, ok);
    send(8'hA5, 3'd0, MODE_ROR, 8'hA5, 1'b1, 10, ok);
    drain(0, 40);

    // Backpressure: output stalled, only three beats fit.
    for (int i = 0; i < 6; i++) begin
      bp_d[i] = 8'($urandom);
      bp_s[i] = 3'($urandom_range(0, 7));
      bp_m[i] = 3'($urandom_range(0, 4));
    end
    drv_out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(bp_d[i], bp_s[i], bp_m[i], ref_model(bp_d[i], int'(bp_s[i]), bp_m[i]), 1'b0, 6,
           ok);
      if (!ok) break;
      acc++;
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready_low", ird[0], 0);
    repeat (3) @(posedge clk);
    #1;
    drv_out_ready = 1'b1;
    for (int i = acc; i < 6; i++) begin
      send(bp_d[i], bp_s[i], bp_m[i], ref_model(bp_d[i], int'(bp_s[i]), bp_m[i]), 1'b0, 20,
           ok);
      chk("bp_late_accepted", ok, 1);
    end
    drain(0, 40);

    // Reset with three beats in flight.
    drv_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) rnd_send(10);
    idle();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk("midrst_in_ready", ird[0], 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    drv_out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", vld[0], 0);
    chk("midrst_out_data", dat[0], 0);
    chk("midrst_out_zero", zer[0], 0);
    repeat (8) @(posedge clk);
    #1;
    send(8'h01, 3'd3, MODE_SLL, 8'h08, 1'b1, 10, ok);
    drain(0, 20);

    // Random traffic with random downstream stalls, pipelined DUT.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) rnd_send(50);
    idle();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    drv_out_ready = 1'b1;
    drain(0, 60);

    // Single-register variant.
    sel = 1;
    sll_sweep();
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) rnd_send(50);
    idle();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    drv_out_ready = 1'b1;
    drain(1, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
